// File: rtl/capture_pix_bram_reader.sv
// capture_pix_bram_reader: streams a run of BRAM port-A words out over valid/ready with a credit-limited FIFO
module capture_pix_bram_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] len, remaining;
  logic [CW-1:0] in_flight, count;
  logic [READ_LATENCY-1:0] ret_v, ret_l;
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic zero_done, last_acc, issue, wr, rd;
  assign len = num_words > MAX_LEN ? MAX_LEN : num_words;
  // credit check: never let outstanding reads plus buffered words exceed the FIFO
  assign issue = (state == ISSUE) && (in_flight + count < DEPTH_C);
  assign wr = ret_v[READ_LATENCY-1];
  assign rd = out_valid && out_ready;
  assign out_valid = count != '0;
  assign out_data = out_valid ? mem[rptr][DATA_W-1:0] : '0;
  assign out_last = out_valid & mem[rptr][DATA_W];
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next-state logic
  always_comb
    state_nx = state == IDLE  ? (start && len != '0 ? ISSUE : IDLE) :
               state == ISSUE ? (issue && remaining == (ADDR_W+1)'(1) ? DRAIN : ISSUE) :
               (last_acc ? IDLE : DRAIN);
  // outputs decoded from state
  always_comb begin
    busy = state != IDLE;
    done = zero_done | (state == DRAIN && last_acc);
    bram_en_a = issue;
  end
  // address/length tracking, return pipeline, FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_addr <= '0;
      remaining <= '0;
      in_flight <= '0;
      count <= '0;
      ret_v <= '0;
      ret_l <= '0;
      wptr <= '0;
      rptr <= '0;
      zero_done <= 1'b0;
      last_acc <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        bram_addr <= start_addr;
        remaining <= len;
      end else if (issue) begin
        bram_addr <= bram_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      zero_done <= state == IDLE && start && len == '0;
      last_acc <= state == IDLE ? 1'b0 : last_acc | (rd && out_last);
      ret_v <= READ_LATENCY'({ret_v, issue});
      ret_l <= READ_LATENCY'({ret_l, issue && remaining == (ADDR_W+1)'(1)});
      in_flight <= in_flight + CW'(issue) - CW'(wr);
      count <= count + CW'(wr) - CW'(rd);
      if (wr) wptr <= wptr == PW'(FIFO_DEPTH-1) ? '0 : wptr + PW'(1);
      if (rd) rptr <= rptr == PW'(FIFO_DEPTH-1) ? '0 : rptr + PW'(1);
      assert (!(wr && !rd && count == DEPTH_C)) else $error("output fifo overflow");
    end
  end
  // FIFO storage: data word plus its last tag
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= {ret_l[READ_LATENCY-1], bram_rd_data};
endmodule
